// File: rtl/vram_slot_arbiter.sv
// N-channel VRAM slot arbiter: reserved fetch, then starved, high-priority and
// round-robin normal channels share one memory port through toggle req/ack.
module vram_slot_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 15,
    localparam int ID_W        = $clog2(NUM_CH)
) (
    input  logic                     CLK21M,
    input  logic                     RESET_N,
    input  logic                     SLOT_STROBE,
    input  logic                     RESV_REQ,
    input  logic [ADDR_W-1:0]        RESV_ADDR,
    input  logic [NUM_CH-1:0]        CH_REQ,
    output logic [NUM_CH-1:0]        CH_ACK,
    input  logic [NUM_CH-1:0]        CH_WE,
    input  logic [NUM_CH-1:0]        CH_HIPRI,
    input  logic [NUM_CH*ADDR_W-1:0] CH_ADDR,
    input  logic [NUM_CH*DATA_W-1:0] CH_WDATA,
    input  logic [NUM_CH*2-1:0]      CH_SIZE,
    output logic                     MEM_VALID,
    output logic [ADDR_W-1:0]        MEM_ADDR,
    output logic [DATA_W-1:0]        MEM_WDATA,
    output logic                     MEM_WE_N,
    output logic [1:0]               MEM_SIZE,
    output logic [ID_W-1:0]          GRANT_ID,
    output logic                     GRANT_RESV,
    output logic [NUM_CH-1:0]        STARVED
);

    localparam int SUM_W = ID_W + 1;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    localparam logic [SUM_W-1:0] NUM_CH_W = SUM_W'(NUM_CH);

    logic [NUM_CH-1:0] ack_r;
    logic [NUM_CH-1:0] starved_r;
    logic [NUM_CH-1:0] pending_s;
    logic [7:0]        cnt_r      [NUM_CH];
    logic [7:0]        cnt_next_s [NUM_CH];
    logic [ID_W-1:0]   rr_ptr_r;
    logic [ID_W-1:0]   grant_id_s;
    logic              grant_valid_s;
    logic              grant_norm_s;
    logic              ch_grant_s;

    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_we_s;
    logic [1:0]        sel_size_s;

    logic              mem_valid_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              mem_we_n_r;
    logic [1:0]        mem_size_r;
    logic [ID_W-1:0]   grant_id_r;
    logic              grant_resv_r;

    // Write addresses are forced onto the natural boundary of the access size.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                     input logic [1:0] sz);
        logic [ADDR_W-1:0] r;
        r = a;
        case (sz)
            2'd1:    r[0]   = 1'b0;
            2'd2:    r[1:0] = 2'b00;
            default: r = a;
        endcase
        return r;
    endfunction

    assign pending_s  = CH_REQ ^ ack_r;
    assign ch_grant_s = SLOT_STROBE && !RESV_REQ && grant_valid_s;

    // Winner selection: later loops override earlier ones, so starved beats hipri beats normal.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_norm_s  = 1'b0;
        grant_id_s    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            logic [SUM_W-1:0] sum;
            logic [ID_W-1:0]  idx;
            sum = {1'b0, rr_ptr_r} + SUM_W'(k);
            if (sum >= NUM_CH_W) begin
                sum = sum - NUM_CH_W;
            end else begin
                sum = sum;
            end
            idx = ID_W'(sum);
            if (pending_s[idx] && !CH_HIPRI[idx]) begin
                grant_valid_s = 1'b1;
                grant_norm_s  = 1'b1;
                grant_id_s    = idx;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_s[i] && CH_HIPRI[i]) begin
                grant_valid_s = 1'b1;
                grant_norm_s  = 1'b0;
                grant_id_s    = ID_W'(i);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_s[i] && starved_r[i]) begin
                grant_valid_s = 1'b1;
                grant_norm_s  = 1'b0;
                grant_id_s    = ID_W'(i);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Fields of the winning channel; reads carry size 0 and illegal size 3 means a byte.
    always_comb begin
        sel_addr_s  = CH_ADDR[grant_id_s*ADDR_W +: ADDR_W];
        sel_wdata_s = CH_WDATA[grant_id_s*DATA_W +: DATA_W];
        sel_we_s    = CH_WE[grant_id_s];
        sel_size_s  = CH_SIZE[{grant_id_s, 1'b0} +: 2];
        if (!sel_we_s || sel_size_s == 2'd3) begin
            sel_size_s = 2'd0;
        end else begin
            sel_size_s = sel_size_s;
        end
    end

    // Next starvation count: only strobe cycles move the counters.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_next_s[i] = cnt_r[i];
            if (!SLOT_STROBE) begin
                cnt_next_s[i] = cnt_r[i];
            end else if (pending_s[i] && !(ch_grant_s && grant_id_s == ID_W'(i))) begin
                cnt_next_s[i] = (cnt_r[i] >= LIMIT) ? LIMIT : cnt_r[i] + 8'd1;
            end else begin
                cnt_next_s[i] = 8'd0;
            end
        end
    end

    // Starvation counters and their registered flags.
    always_ff @(posedge CLK21M) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= 8'd0;
            end
            starved_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i]     <= cnt_next_s[i];
                starved_r[i] <= (cnt_next_s[i] == LIMIT);
            end
        end
    end

    // Memory port, grant reporting, ack toggles and the round-robin pointer.
    always_ff @(posedge CLK21M) begin
        if (!RESET_N) begin
            mem_valid_r  <= 1'b0;
            mem_addr_r   <= '1;
            mem_wdata_r  <= '0;
            mem_we_n_r   <= 1'b1;
            mem_size_r   <= 2'd0;
            grant_id_r   <= '0;
            grant_resv_r <= 1'b0;
            ack_r        <= '0;
            rr_ptr_r     <= ID_W'(NUM_CH - 1);
        end else begin
            mem_valid_r  <= 1'b0;
            mem_we_n_r   <= 1'b1;
            grant_resv_r <= 1'b0;
            mem_size_r   <= 2'd0;
            if (SLOT_STROBE && RESV_REQ) begin
                mem_valid_r  <= 1'b1;
                mem_addr_r   <= RESV_ADDR;
                grant_resv_r <= 1'b1;
            end else if (ch_grant_s) begin
                mem_valid_r <= 1'b1;
                mem_we_n_r  <= ~sel_we_s;
                mem_size_r  <= sel_size_s;
                mem_addr_r  <= sel_we_s ? align_addr(sel_addr_s, sel_size_s) : sel_addr_s;
                if (sel_we_s) begin
                    mem_wdata_r <= sel_wdata_s;
                end else begin
                    mem_wdata_r <= mem_wdata_r;
                end
                grant_id_r            <= grant_id_s;
                ack_r[grant_id_s]     <= ~ack_r[grant_id_s];
                if (grant_norm_s) begin
                    rr_ptr_r <= grant_id_s;
                end else begin
                    rr_ptr_r <= rr_ptr_r;
                end
            end else begin
                mem_addr_r <= mem_addr_r;
            end
        end
    end

    assign CH_ACK     = ack_r;
    assign MEM_VALID  = mem_valid_r;
    assign MEM_ADDR   = mem_addr_r;
    assign MEM_WDATA  = mem_wdata_r;
    assign MEM_WE_N   = mem_we_n_r;
    assign MEM_SIZE   = mem_size_r;
    assign GRANT_ID   = grant_id_r;
    assign GRANT_RESV = grant_resv_r;
    assign STARVED    = starved_r;

endmodule
